// File: rtl/operand_fetch.sv
// Operand fetch: scoreboarded RAW/WAW hazard stall, operand select, one-slot output register.
// Latency: one cycle from fire (in_valid && in_ready) to out_valid.
// Backpressure: in_ready drops on hazard or on a full slot that execute is not consuming.
// Optional feature: define OPERAND_FETCH_BYPASS_EN to forward same-cycle writeback data.
module operand_fetch #(
   parameter int STALL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_pc,
   input  logic [4:0]         in_rs1,
   input  logic [4:0]         in_rs2,
   input  logic [4:0]         in_rd,
   input  logic               in_rd_wr,
   output logic [4:0]         rf_rd_addr0,
   output logic [4:0]         rf_rd_addr1,
   input  logic [31:0]        rf_rd_data0,
   input  logic [31:0]        rf_rd_data1,
   input  logic               wb_ena,
   input  logic [4:0]         wb_addr,
   input  logic [31:0]        wb_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_pc,
   output logic [31:0]        out_rs1_data,
   output logic [31:0]        out_rs2_data,
   output logic [4:0]         out_rd,
   output logic               out_rd_wr,
   output logic [STALL_W-1:0] stall_cycles
);

   // One bit per architectural register with a write in flight; bit 0 never set.
   logic [31:0] busy;
   logic [31:0] busy_nxt;

   logic        wb_rs1;
   logic        wb_rs2;
   logic        wb_rd;
   logic        rs1_hit;
   logic        rs2_hit;
   logic        waw;
   logic        hazard;
   logic        fire;
   logic [31:0] rs1_op;
   logic [31:0] rs2_op;

   assign rf_rd_addr0 = in_rs1;
   assign rf_rd_addr1 = in_rs2;

   assign wb_rs1 = wb_ena && (wb_addr == in_rs1);
   assign wb_rs2 = wb_ena && (wb_addr == in_rs2);
   assign wb_rd  = wb_ena && (wb_addr == in_rd);

   // Hazard detection and operand select; the bypass build forwards writeback data
   // because the register file only captures the write at the clock edge.
   always_comb begin
      rs1_hit = (in_rs1 != 5'd0) && busy[in_rs1];
      rs2_hit = (in_rs2 != 5'd0) && busy[in_rs2];
      rs1_op  = rf_rd_data0;
      rs2_op  = rf_rd_data1;
`ifdef OPERAND_FETCH_BYPASS_EN
      if (wb_rs1) begin
         rs1_hit = 1'b0;
         rs1_op  = wb_data;
      end
      if (wb_rs2) begin
         rs2_hit = 1'b0;
         rs2_op  = wb_data;
      end
`endif
      if (in_rs1 == 5'd0) rs1_op = 32'd0;
      if (in_rs2 == 5'd0) rs2_op = 32'd0;
      // A same-cycle writeback retires the older write, so the new one may take its place.
      waw    = in_rd_wr && (in_rd != 5'd0) && busy[in_rd] && !wb_rd;
      hazard = rs1_hit || rs2_hit || waw;
   end

`ifndef OPERAND_FETCH_BYPASS_EN
   // Writeback data only reaches operands through the register file in this build.
   logic unused_wb_data;
   assign unused_wb_data = ^wb_data;
`endif

   assign in_ready = !hazard && (!out_valid || out_ready);
   assign fire     = in_valid && in_ready;

   // Scoreboard next state: clear on writeback, then set on fire so a same-index set wins.
   always_comb begin
      busy_nxt = busy;
      if (wb_ena && (wb_addr != 5'd0)) busy_nxt[wb_addr] = 1'b0;
      if (fire && in_rd_wr && (in_rd != 5'd0)) busy_nxt[in_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (rst) busy <= 32'd0;
      else     busy <= busy_nxt;
   end

   // Output slot: load on fire, drain when consumed, data held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_pc       <= 32'd0;
         out_rs1_data <= 32'd0;
         out_rs2_data <= 32'd0;
         out_rd       <= 5'd0;
         out_rd_wr    <= 1'b0;
      end else if (fire) begin
         out_valid    <= 1'b1;
         out_pc       <= in_pc;
         out_rs1_data <= rs1_op;
         out_rs2_data <= rs2_op;
         out_rd       <= in_rd;
         out_rd_wr    <= in_rd_wr;
      end else if (out_valid && out_ready) begin
         out_valid    <= 1'b0;
      end
   end

   // Saturating count of cycles lost to hazards; slot backpressure is not counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (in_valid && hazard && (stall_cycles != {STALL_W{1'b1}})) begin
         stall_cycles <= stall_cycles + {{(STALL_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: scoreboard of expected output-slot contents plus directed checks.
// Expectations follow OPERAND_FETCH_BYPASS_EN when it is defined for the build.
// The register file is modelled here and written on the writeback strobe.
module tb_operand_fetch;

`ifdef OPERAND_FETCH_BYPASS_EN
   localparam int EXP_STALL = 3;
`else
   localparam int EXP_STALL = 4;
`endif

   typedef struct {
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [4:0]  rd;
      logic        rd_wr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic        in_rd_wr;
   logic [4:0]  rf_rd_addr0, rf_rd_addr1;
   logic [31:0] rf_rd_data0, rf_rd_data1;
   logic        wb_ena;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc, out_rs1_data, out_rs2_data;
   logic [4:0]  out_rd;
   logic        out_rd_wr;
   logic [3:0]  stall_cycles;

   logic [31:0] rf [32];
   exp_t        sb [$];
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   operand_fetch #(.STALL_W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wr(in_rd_wr),
      .rf_rd_addr0(rf_rd_addr0), .rf_rd_addr1(rf_rd_addr1),
      .rf_rd_data0(rf_rd_data0), .rf_rd_data1(rf_rd_data1),
      .wb_ena(wb_ena), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
      .out_rd(out_rd), .out_rd_wr(out_rd_wr), .stall_cycles(stall_cycles)
   );

   // Register file model: raw storage (x0 deliberately holds garbage), write at the edge.
   assign rf_rd_data0 = rf[rf_rd_addr0];
   assign rf_rd_data1 = rf[rf_rd_addr1];
   always @(posedge clk) if (wb_ena && wb_addr != 5'd0) rf[wb_addr] <= wb_data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_op(input logic [4:0] rs);
      if (rs == 5'd0) return 32'd0;
`ifdef OPERAND_FETCH_BYPASS_EN
      if (wb_ena && wb_addr == rs) return wb_data;
`endif
      return rf[rs];
   endfunction

   // Called just after the falling edge with inputs driven: compare a consumed slot,
   // record an accepted instruction.
   task automatic settle();
      exp_t e;
      #1;
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else begin
               e = sb.pop_front();
               chk("out_pc", out_pc, e.pc);
               chk("out_rs1_data", out_rs1_data, e.rs1_data);
               chk("out_rs2_data", out_rs2_data, e.rs2_data);
               chk("out_rd", 32'(out_rd), 32'(e.rd));
               chk("out_rd_wr", 32'(out_rd_wr), 32'(e.rd_wr));
            end
         end
         if (in_valid && in_ready) begin
            e.pc = in_pc; e.rs1_data = exp_op(in_rs1); e.rs2_data = exp_op(in_rs2);
            e.rd = in_rd; e.rd_wr = in_rd_wr;
            sb.push_back(e);
         end
      end
   endtask

   task automatic edge_();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic wr);
      in_valid = 1'b1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_wr = wr;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0; wb_ena = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin settle(); edge_(); end
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; wb_ena = 1'b0; out_ready = 1'b1;
      edge_(); edge_();
      sb.delete();
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
      rf[0] = 32'hBAD0_BAD0; rf[2] = 32'd5; rf[3] = 32'd7;
      rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
      in_rd_wr = 1'b0; wb_ena = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
      @(negedge clk);
      do_reset();

      // Reset state
      settle();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_rs1", out_rs1_data, 32'd0);
      chk("rst_out_rd_wr", 32'(out_rd_wr), 32'd0);
      chk("rst_stall", 32'(stall_cycles), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", dut.busy, 32'd0);
      edge_();

      // Basic issue: x1 := f(x2, x3)
      drive(32'h100, 5'd2, 5'd3, 5'd1, 1'b1);
      settle(); edge_();
      in_valid = 1'b0;
      settle();
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      chk("t1_rs1", out_rs1_data, 32'd5);
      chk("t1_rs2", out_rs2_data, 32'd7);
      chk("t1_rd", 32'(out_rd), 32'd1);
      chk("t1_busy1", 32'(dut.busy[1]), 32'd1);
      edge_();

      // RAW stall on x5, then writeback releases it
      drive(32'h104, 5'd0, 5'd0, 5'd5, 1'b1);
      settle(); edge_();
      drive(32'h108, 5'd5, 5'd0, 5'd6, 1'b1);
      for (int i = 0; i < 3; i++) begin
         settle(); chk("raw_in_ready", 32'(in_ready), 32'd0); edge_();
      end
      wb_ena = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
      settle();
      chk("raw_stall_cnt", 32'(stall_cycles), 32'd3);
`ifdef OPERAND_FETCH_BYPASS_EN
      chk("raw_wb_fire", 32'(in_ready), 32'd1);
      edge_();
      wb_ena = 1'b0; in_valid = 1'b0;
`else
      chk("raw_wb_cycle", 32'(in_ready), 32'd0);
      edge_();
      wb_ena = 1'b0;
      settle(); chk("raw_after_wb", 32'(in_ready), 32'd1); edge_();
      in_valid = 1'b0;
`endif
      idle(2);

      // x0 sources and attempted write to x0
      drive(32'h10C, 5'd0, 5'd0, 5'd0, 1'b1);
      settle(); chk("x0_in_ready", 32'(in_ready), 32'd1); edge_();
      in_valid = 1'b0;
      settle(); chk("x0_busy0", 32'(dut.busy[0]), 32'd0); edge_();
      idle(1);

      // Backpressure: slot full, execute not ready
      out_ready = 1'b0;
      drive(32'h110, 5'd2, 5'd3, 5'd8, 1'b1);
      settle(); edge_();
      drive(32'h114, 5'd3, 5'd2, 5'd9, 1'b1);
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_pc", out_pc, 32'h110);
         chk("bp_out_rs1", out_rs1_data, 32'd5);
         chk("bp_out_rd", 32'(out_rd), 32'd8);
         edge_();
      end
      out_ready = 1'b1;
      settle();
      chk("bp_release", 32'(in_ready), 32'd1);
      chk("bp_stall_cnt", 32'(stall_cycles), 32'(EXP_STALL));
      edge_();
      in_valid = 1'b0;
      settle(); chk("bp_new_pc", out_pc, 32'h114); edge_();

      // WAW stall, then set and clear of x7 in the same cycle
      drive(32'h118, 5'd0, 5'd0, 5'd7, 1'b1);
      settle(); edge_();
      drive(32'h11C, 5'd0, 5'd0, 5'd7, 1'b1);
      settle(); chk("waw_stall", 32'(in_ready), 32'd0); edge_();
      wb_ena = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
      settle(); chk("waw_wb_fire", 32'(in_ready), 32'd1); edge_();
      wb_ena = 1'b0; in_valid = 1'b0;
      settle(); chk("set_wins_busy7", 32'(dut.busy[7]), 32'd1); edge_();
      idle(1);

      // Counter saturation, then reset in the middle of a stall
      do_reset();
      drive(32'h120, 5'd0, 5'd0, 5'd10, 1'b1);
      settle(); edge_();
      out_ready = 1'b0;
      drive(32'h124, 5'd10, 5'd0, 5'd11, 1'b1);
      for (int i = 0; i < 20; i++) begin settle(); edge_(); end
      settle(); chk("sat_stall", 32'(stall_cycles), 32'd15);
      chk("sat_out_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      edge_();
      rst = 1'b0; sb.delete();
      settle();
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_pc", out_pc, 32'd0);
      chk("mid_rst_out_rd", 32'(out_rd), 32'd0);
      chk("mid_rst_stall", 32'(stall_cycles), 32'd0);
      chk("mid_rst_busy", dut.busy, 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      edge_();
      in_valid = 1'b0; out_ready = 1'b1;
      settle(); edge_();
      idle(1);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
